word_break: RTL and testbench
=============================

Name: word_break

Overview:
- Upstream neighbour of the byte-to-word join stage.
- Accepts WORD_IN_SIZE-bit words over a valid/ready handshake and buffers them in a small word FIFO.
- Serialises each word into WORD_OUT_SIZE-bit slices, most-significant slice first, over a valid/ready byte interface.
- MSB-first order matches the join stage, which fills [31:24] first, so a break→join chain reproduces the original word.

Parameters:
- WORD_IN_SIZE, 32, width of the input word; must be an integer multiple of WORD_OUT_SIZE.
- WORD_OUT_SIZE, 8, width of each output slice.
- DEPTH, 2, word FIFO depth; power of two, ≥2.

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- word_in  input  WORD_IN_SIZE  word to serialise.
- valid_in  input  1  word_in valid.
- ready_o  output  1  block can accept a word; a transfer occurs on valid_in && ready_o.
- data_out  output  WORD_OUT_SIZE  current slice.
- valid_o  output  1  data_out valid.
- ready_in  input  1  downstream accepts a slice; a transfer occurs on valid_o && ready_in.
- busy_o  output  1  FIFO non-empty or a word is in the shifter.

Behaviour:
- SLICES = WORD_IN_SIZE/WORD_OUT_SIZE (4 at defaults).
- Reset values:
  - FIFO pointers 0, count 0.
  - Shifter contents 0, slice index 0.
  - State EMPTY; valid_o 0, data_out 0, busy_o 0.
  - ready_o 1 while reset is asserted and after release, because it is decoded from count.
- FIFO:
  - Push on valid_in && ready_o.
  - ready_o = (count != DEPTH), combinational from registered count.
  - No write-through when full; valid_in while full is ignored and must be held by upstream.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Shifter FSM states:
  - EMPTY: valid_o=0. If the FIFO is non-empty, pop, load the shifter and set index=0, go to SEND.
  - SEND: valid_o=1, data_out = shifter[WORD_IN_SIZE-1 -: WORD_OUT_SIZE].
    - Handshake with index<SLICES-1: shift left by WORD_OUT_SIZE, index++.
    - Handshake with index==SLICES-1 and FIFO non-empty: pop and reload the same edge, index=0, stay in SEND. No bubble between words.
    - Handshake with index==SLICES-1 and FIFO empty: go to EMPTY.
    - No handshake: hold shifter, index and data_out stable. valid_o must not drop once asserted until the handshake.
- Latency:
  - Word pushed at edge N, shifter empty: loaded at edge N+1, first slice valid after N+1.
  - Sustained throughput is 1 slice/cycle.
- Capacity: DEPTH words in the FIFO plus 1 in the shifter. With ready_in=0, ready_o deasserts after DEPTH+1 accepted words.
- busy_o = (count!=0) || (state==SEND).
- Reset mid-word: all in-flight data is discarded, with no partial slices after release. First activity after release is a fresh word.
- Width check: elaboration-time error if WORD_IN_SIZE % WORD_OUT_SIZE != 0 or DEPTH is not a power of two.

Decomposition:
- Package word_pkg: the SLICES constant, state typedef (EMPTY, SEND), and the default WORD_IN_SIZE/WORD_OUT_SIZE shared with the join stage.
- Sub-module word_fifo:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count; same asynchronous reset.
  - word_break instantiates it and holds the shifter FSM.

Test Plan:
- Single word 0xAABBCCDD, ready_in=1 → data_out AA, BB, CC, DD on 4 consecutive cycles starting the cycle after load; then valid_o=0 and busy_o=0.
- Back-to-back words 0x01020304 and 0x05060708, ready_in=1 → 8 consecutive valid slices 01..08 with no bubble between 04 and 05.
- ready_in=0, offer 4 words with valid_in held → ready_o drops after the 3rd accept and the 4th is held off. Raise ready_in → 12 slices in order, and the 4th word is accepted as soon as ready_o returns high.
- Word 0x11223344, ready_in toggled 1,0,0,1,1,0,1 → data_out holds steady during the 0 cycles; output sequence is exactly 11, 22, 33, 44.
- Reset asserted after slice 22 of 0x11223344, with a second word queued → valid_o=0, ready_o=1, busy_o=0 during reset; nothing emitted after release until a new word is pushed.
- word_break chained to the join stage, random words → each reassembled word equals its input word, in order.

Source files
------------

// File: rtl/word_pkg.sv
// word_pkg: widths and shifter state shared by the word break and join stages.
package word_pkg;

    localparam int WORD_IN_SIZE  = 32;
    localparam int WORD_OUT_SIZE = 8;
    localparam int SLICES        = WORD_IN_SIZE / WORD_OUT_SIZE;

    typedef enum logic {EMPTY, SEND} state_t;

    // Index width that stays legal when only one slice or entry exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// word_fifo: small power-of-two word FIFO with occupancy count, no write-through when full.
module word_fifo
    import word_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = idx_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = r_count == (AW+1)'(DEPTH);
    assign empty  = r_count == '0;
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/word_break.sv
// word_break: buffers input words and serialises each one MSB slice first,
// reloading on the last slice so consecutive words stream without a bubble.
module word_break
    import word_pkg::*;
#(
    parameter int WORD_IN_SIZE  = word_pkg::WORD_IN_SIZE,
    parameter int WORD_OUT_SIZE = word_pkg::WORD_OUT_SIZE,
    parameter int DEPTH         = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WORD_IN_SIZE-1:0]  word_in,
    input  logic                     valid_in,
    output logic                     ready_o,
    output logic [WORD_OUT_SIZE-1:0] data_out,
    output logic                     valid_o,
    input  logic                     ready_in,
    output logic                     busy_o
);

    localparam int N_SLICES = WORD_IN_SIZE / WORD_OUT_SIZE;
    localparam int IW       = idx_width(N_SLICES);
    localparam int CW       = $clog2(DEPTH) + 1;

    if ((WORD_IN_SIZE % WORD_OUT_SIZE) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("word_break: WORD_IN_SIZE must be a multiple of WORD_OUT_SIZE and DEPTH a power of two >= 2");
    end

    state_t                  r_state;
    state_t                  w_next_state;
    logic [WORD_IN_SIZE-1:0] r_shift;
    logic [WORD_IN_SIZE-1:0] w_next_shift;
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           w_next_idx;
    logic [WORD_IN_SIZE-1:0] w_rdata;
    logic [CW-1:0]           w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_hs;
    logic                    w_last;

    word_fifo #(.WIDTH(WORD_IN_SIZE), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (valid_in && ready_o),
        .pop   (w_pop),
        .wdata (word_in),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign ready_o  = !w_full;
    assign valid_o  = r_state == SEND;
    assign data_out = r_shift[WORD_IN_SIZE-1 -: WORD_OUT_SIZE];
    assign busy_o   = (w_count != '0) || (r_state == SEND);
    assign w_hs     = valid_o && ready_in;
    assign w_last   = r_idx == IW'(N_SLICES - 1);

    always_comb begin
        w_next_state = r_state;
        w_next_shift = r_shift;
        w_next_idx   = r_idx;
        w_pop        = 1'b0;
        if (r_state == EMPTY) begin
            if (!w_empty) begin
                w_pop        = 1'b1;
                w_next_shift = w_rdata;
                w_next_idx   = '0;
                w_next_state = SEND;
            end
        end else if (w_hs) begin
            if (!w_last) begin
                w_next_shift = r_shift << WORD_OUT_SIZE;
                w_next_idx   = r_idx + 1'b1;
            end else if (!w_empty) begin
                w_pop        = 1'b1;
                w_next_shift = w_rdata;
                w_next_idx   = '0;
            end else begin
                w_next_state = EMPTY;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_shift <= w_next_shift;
            r_idx   <= w_next_idx;
        end
    end

endmodule

// File: tb/tb_word_break.sv
// tb_word_break: scoreboard bench; stimulus queues expected slices and words,
// a negedge monitor checks every slice handshake, stall hold and word reassembly.
module tb_word_break;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] word_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic        ready_o;
    logic [7:0]  data_out;
    logic        valid_o;
    logic        busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] word_q[$];
    logic        done = 1'b0;

    word_break dut (
        .clock    (clock),
        .reset    (reset),
        .word_in  (word_in),
        .valid_in (valid_in),
        .ready_o  (ready_o),
        .data_out (data_out),
        .valid_o  (valid_o),
        .ready_in (ready_in),
        .busy_o   (busy_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: inputs change only between posedge and negedge, so a negedge sample
    // reflects exactly what the next posedge will see.
    initial begin
        logic        prev_stall;
        logic [7:0]  prev_data;
        logic [31:0] asm_word;
        int          asm_n;
        prev_stall = 1'b0;
        prev_data  = '0;
        asm_word   = '0;
        asm_n      = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
                asm_n      = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(valid_o), 32'd1);
                    chk("hold_data", 32'(data_out), 32'(prev_data));
                end
                if (valid_o && ready_in) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_slice: got %h expected none", data_out);
                    end else begin
                        chk("slice", 32'(data_out), 32'(exp_q.pop_front()));
                    end
                    asm_word = {asm_word[23:0], data_out};
                    asm_n++;
                    if (asm_n == 4) begin
                        asm_n = 0;
                        if (word_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL extra_word: got %h expected none", asm_word);
                        end else begin
                            chk("rejoined_word", asm_word, word_q.pop_front());
                        end
                    end
                end
                prev_stall = valid_o && !ready_in;
                prev_data  = data_out;
            end
        end
    end

    task automatic push(input logic [31:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
        word_q.push_back(w);
        word_in  = w;
        valid_in = 1'b1;
        @(negedge clock);
        while (!ready_o && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("accept", 32'(ready_o), 32'd1);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic run(input string tag, input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
            chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        end
        @(negedge clock);
        chk({tag, "_end_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid_o && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({tag, "_valid_seen"}, 32'(valid_o), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o || valid_o) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        logic [6:0] pat;
        #12;
        reset_outputs("rst_in");
        @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        reset_outputs("rst_out");

        // Single word: idle on the push cycle, then four slices, then idle.
        ready_in = 1'b1;
        push(32'hAABBCCDD);
        @(negedge clock);
        chk("t1_pre_valid", 32'(valid_o), 32'd0);
        chk("t1_pre_busy", 32'(busy_o), 32'd1);
        run("t1", 4);

        // Back-to-back words stream eight slices with no gap.
        @(posedge clock);
        #1;
        push(32'h01020304);
        push(32'h05060708);
        run("t2", 8);

        // Backpressure: three words fill FIFO plus shifter, fourth is held off.
        @(posedge clock);
        #1;
        ready_in = 1'b0;
        push(32'h10111213);
        push(32'h20212223);
        push(32'h30313233);
        @(negedge clock);
        chk("t3_full_ready", 32'(ready_o), 32'd0);
        chk("t3_full_valid", 32'(valid_o), 32'd1);
        chk("t3_full_data", 32'(data_out), 32'h10);
        fork
            push(32'h40414243);
            begin
                repeat (5) @(posedge clock);
                #1;
                chk("t3_still_full", 32'(ready_o), 32'd0);
                ready_in = 1'b1;
            end
        join
        drain("t3");

        // Stalls on the output must hold the current slice.
        @(posedge clock);
        #1;
        ready_in = 1'b0;
        push(32'h11223344);
        wait_valid("t4");
        pat = 7'b1001101;
        for (int i = 0; i < 7; i++) begin
            ready_in = pat[6-i];
            @(posedge clock);
            #1;
        end
        ready_in = 1'b1;
        @(negedge clock);
        chk("t4_end_valid", 32'(valid_o), 32'd0);
        chk("t4_end_busy", 32'(busy_o), 32'd0);

        // Reset mid-word with a second word queued discards everything.
        @(posedge clock);
        #1;
        ready_in = 1'b0;
        push(32'h11223344);
        push(32'h55667788);
        wait_valid("t5");
        ready_in = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        ready_in = 1'b0;
        #2;
        reset = 1'b1;
        exp_q.delete();
        word_q.delete();
        #1;
        reset_outputs("t5_rst");
        @(negedge clock);
        #2;
        reset = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("t5_idle", 32'(valid_o), 32'd0);
        end
        @(posedge clock);
        #1;
        push(32'hCAFEF00D);
        drain("t5");

        // Random words and random backpressure; monitor rejoins each word.
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clock);
                        #1;
                    end
                    push($urandom);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1;
                    ready_in = $urandom_range(0, 3) != 0;
                end
            end
        join
        ready_in = 1'b1;
        drain("t6");
        chk("t6_words_left", 32'(word_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
